// File: rtl/mem_unit.sv
// Word-addressed RAM: synchronous write, write-first registered read (1 cycle), async clear.
// No backpressure: one write and one read are accepted every cycle; out-of-range accesses are dropped/read as zero.
module mem_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] wr_addr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] d_in,
  input  logic                  rd_req,
  input  logic [DATA_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0]      wr_idx;
  logic [IDX_W-1:0]      rd_idx;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  wr_hit;

  assign wr_idx = wr_addr[IDX_W-1:0];
  assign rd_idx = rd_addr[IDX_W-1:0];

  // Any address bit above the index field makes the access out of range.
  assign wr_ok  = ((wr_addr >> IDX_W) == '0);
  assign rd_ok  = ((rd_addr >> IDX_W) == '0);
  assign wr_hit = wr_en && wr_ok && (wr_idx == rd_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en && wr_ok) begin
      mem[wr_idx] <= d_in;
    end
  end

  // Same-index write on the read edge forwards the new data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else if (rd_req) begin
      if (!rd_ok) begin
        data_out <= '0;
      end else if (wr_hit) begin
        data_out <= d_in;
      end else begin
        data_out <= mem[rd_idx];
      end
    end
  end

endmodule

// File: tb/tb_mem_unit.sv
// Directed bench for mem_unit: read results are queued at issue time and checked one cycle later.
module tb_mem_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] wr_addr;
  logic        wr_en;
  logic [31:0] d_in;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic [31:0] data_out;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] exp_q [$];
  string       tag_q [$];

  mem_unit #(.DATA_WIDTH(32), .DEPTH(256)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_addr  (wr_addr),
    .wr_en    (wr_en),
    .d_in     (d_in),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .data_out (data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic drive(input logic we, input logic [31:0] wa, input logic [31:0] d,
                       input logic rr, input logic [31:0] ra);
    wr_en   = we;
    wr_addr = wa;
    d_in    = d;
    rd_req  = rr;
    rd_addr = ra;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: data_out=%h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_check();
    logic [31:0] e;
    string       t;
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL scoreboard_underflow: got data_out=%h with no expected entry", data_out);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, data_out, e);
    end
  endtask

  // One cycle with a read issued; optional concurrent write.
  task automatic cyc_rd(input logic we, input logic [31:0] wa, input logic [31:0] d,
                        input logic [31:0] ra, input logic [31:0] exp, input string tag);
    drive(we, wa, d, 1'b1, ra);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    tick();
    pop_check();
  endtask

  task automatic cyc_wr(input logic [31:0] wa, input logic [31:0] d);
    drive(1'b1, wa, d, 1'b0, 32'h0);
    tick();
  endtask

  initial begin
    // Reset held with random inputs, spanning a clock edge.
    rst_n = 1'b0;
    drive(1'b1, $urandom, $urandom, 1'b1, $urandom);
    #4;
    drive(1'b1, $urandom, $urandom, 1'b1, $urandom);
    #6;
    check("reset_data_out", data_out, 32'h0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    rst_n = 1'b1;
    tick();
    cyc_rd(1'b0, 32'h0, 32'h0, 32'h54, 32'h0, "post_reset_rd_54");

    // Directed writes, then a bubble-free read burst.
    cyc_wr(32'h54, 32'hAAAA5678);
    cyc_wr(32'h55, 32'hBBBB5678);
    cyc_wr(32'h56, 32'hCCCC5678);
    cyc_wr(32'h57, 32'hDDDD5678);
    cyc_rd(1'b0, 32'h0, 32'h0, 32'h54, 32'hAAAA5678, "burst_54");
    cyc_rd(1'b0, 32'h0, 32'h0, 32'h55, 32'hBBBB5678, "burst_55");
    cyc_rd(1'b0, 32'h0, 32'h0, 32'h56, 32'hCCCC5678, "burst_56");
    cyc_rd(1'b0, 32'h0, 32'h0, 32'h57, 32'hDDDD5678, "burst_57");

    // rd_req low: output holds, even with address and writes changing.
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h54);
    tick();
    check("hold_1", data_out, 32'hDDDD5678);
    drive(1'b1, 32'h57, 32'h0BAD0BAD, 1'b0, 32'h10);
    tick();
    check("hold_2", data_out, 32'hDDDD5678);
    cyc_wr(32'h57, 32'hDDDD5678);

    // Read-during-write, same and different index.
    cyc_wr(32'h10, 32'h11111111);
    cyc_rd(1'b0, 32'h0, 32'h0, 32'h10, 32'h11111111, "rdw_before");
    cyc_rd(1'b1, 32'h10, 32'h22222222, 32'h10, 32'h22222222, "rdw_same_edge");
    cyc_rd(1'b0, 32'h0, 32'h0, 32'h10, 32'h22222222, "rdw_after");
    cyc_rd(1'b1, 32'h11, 32'h33333333, 32'h54, 32'hAAAA5678, "rdw_diff_idx");
    cyc_rd(1'b0, 32'h0, 32'h0, 32'h11, 32'h33333333, "rdw_diff_written");

    // Out-of-range write aliasing 0x54 is dropped; out-of-range reads load zero.
    cyc_wr(32'h154, 32'h12345678);
    cyc_rd(1'b0, 32'h0, 32'h0, 32'h54, 32'hAAAA5678, "oor_wr_no_alias");
    cyc_rd(1'b0, 32'h0, 32'h0, 32'h100, 32'h0, "oor_rd_100");
    cyc_rd(1'b0, 32'h0, 32'h0, 32'h55, 32'hBBBB5678, "oor_rd_recover");
    cyc_rd(1'b1, 32'h154, 32'h12345678, 32'h154, 32'h0, "oor_rd_wr_same");
    cyc_rd(1'b0, 32'h0, 32'h0, 32'h54, 32'hAAAA5678, "oor_wr_no_alias_2");

    // Async reset pulse between edges while a read is pending.
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h55);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_immediate", data_out, 32'h0);
    #2;
    rst_n = 1'b1;
    exp_q.push_back(32'h0);
    tag_q.push_back("rd_55_after_rst");
    tick();
    pop_check();
    cyc_rd(1'b0, 32'h0, 32'h0, 32'h10, 32'h0, "rd_10_after_rst");

    // Boundary indices and their neighbours.
    cyc_wr(32'h00, 32'hFFFFFFFF);
    cyc_wr(32'hFF, 32'h00000001);
    cyc_rd(1'b0, 32'h0, 32'h0, 32'h00, 32'hFFFFFFFF, "bound_00");
    cyc_rd(1'b0, 32'h0, 32'h0, 32'hFF, 32'h00000001, "bound_ff");
    cyc_rd(1'b0, 32'h0, 32'h0, 32'h01, 32'h0, "bound_01_neighbour");
    cyc_rd(1'b0, 32'h0, 32'h0, 32'hFE, 32'h0, "bound_fe_neighbour");

    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $error("FAIL scoreboard_leftover: %0d entries remain, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
